// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Size encodings, FSM states and a byte-count helper.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_X = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    REQ0,
    WAIT0,
    REQ1,
    WAIT1,
    DONE
  } state_t;

  function automatic logic [2:0] size_bytes(
    input logic [1:0] sz
  );
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// Pipeline request/response and memory beat bundles.
// Ports: lsu_req_if (master=pipeline, slave=lsu), lsu_mem_if (master=lsu, slave=memory).
interface lsu_req_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsign;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size,
    output req_unsign, req_addr, req_wdata,
    input  req_ready, resp_valid,
    input  resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_size,
    input  req_unsign, req_addr, req_wdata,
    output req_ready, resp_valid,
    output resp_rdata, resp_err
  );
endinterface

interface lsu_mem_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_mask;
  logic [31:0]       mem_wdata;
  logic              mem_rsp_valid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req_valid, mem_we, mem_addr,
    output mem_mask, mem_wdata,
    input  mem_req_ready, mem_rsp_valid,
    input  mem_rdata
  );

  modport slave (
    input  mem_req_valid, mem_we, mem_addr,
    input  mem_mask, mem_wdata,
    output mem_req_ready, mem_rsp_valid,
    output mem_rdata
  );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane math: 8-bit span mask, shifted store data, extended load.
// Ports: off/size/unsign/rbuf/wdata in; m8/w64/rdata out.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        unsign,
  input  logic [63:0] rbuf,
  input  logic [31:0] wdata,
  output logic [7:0]  m8,
  output logic [63:0] w64,
  output logic [31:0] rdata
);

  logic [7:0]  ones;
  logic [31:0] sh;

  always_comb begin
    ones  = 8'((9'd1 << size_bytes(size)) - 9'd1);
    m8    = ones << off;
    w64   = {32'b0, wdata} << {off, 3'b000};
    sh    = 32'(rbuf >> {off, 3'b000});
    rdata = sh;
    case (size)
      SZ_B: rdata = unsign ? {24'b0, sh[7:0]}
                           : {{24{sh[7]}}, sh[7:0]};
      SZ_H: rdata = unsign ? {16'b0, sh[15:0]}
                           : {{16{sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: one or two memory beats per access.
// Ports: clk, rst, req (lsu_req_if.slave), mem (lsu_mem_if.master).
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic       clk,
  input  logic       rst,
  lsu_req_if.slave   req,
  lsu_mem_if.master  mem
);

  state_t            state, state_nx;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_uns;
  logic [1:0]        r_off;
  logic [ADDR_W-3:0] r_word;
  logic [ADDR_W-3:0] word1;
  logic [31:0]       r_wdata;
  logic              r_err;
  logic [63:0]       rbuf;
  logic [7:0]        m8;
  logic [63:0]       w64;
  logic [31:0]       ld;

  assign word1 = r_word + (ADDR_W-2)'(1);

  lsu_align u_align (
    .off    (r_off),
    .size   (r_size),
    .unsign (r_uns),
    .rbuf   (rbuf),
    .wdata  (r_wdata),
    .m8     (m8),
    .w64    (w64),
    .rdata  (ld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      r_we    <= 1'b0;
      r_size  <= SZ_B;
      r_uns   <= 1'b0;
      r_off   <= 2'b0;
      r_word  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
      rbuf    <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req.req_valid) begin
        r_we    <= req.req_we;
        r_size  <= req.req_size;
        r_uns   <= req.req_unsign;
        r_off   <= req.req_addr[1:0];
        r_word  <= req.req_addr[ADDR_W-1:2];
        r_wdata <= req.req_wdata;
        r_err   <= (req.req_size == SZ_X);
      end
      if (state == WAIT0 && mem.mem_rsp_valid)
        rbuf[31:0] <= mem.mem_rdata;
      if (state == WAIT1 && mem.mem_rsp_valid)
        rbuf[63:32] <= mem.mem_rdata;
    end
  end

  always_comb begin
    state_nx          = state;
    req.req_ready     = 1'b0;
    req.resp_valid    = 1'b0;
    req.resp_rdata    = '0;
    req.resp_err      = 1'b0;
    mem.mem_req_valid = 1'b0;
    mem.mem_we        = 1'b0;
    mem.mem_addr      = '0;
    mem.mem_mask      = '0;
    mem.mem_wdata     = '0;
    unique case (state)
      IDLE: begin
        req.req_ready = 1'b1;
        if (req.req_valid)
          state_nx = (req.req_size == SZ_X) ? DONE : REQ0;
      end
      REQ0: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_we        = r_we;
        mem.mem_addr      = {r_word, 2'b00};
        mem.mem_mask      = m8[3:0];
        mem.mem_wdata     = w64[31:0];
        if (mem.mem_req_ready)
          state_nx = WAIT0;
      end
      WAIT0: begin
        // Upper mask nibble non-zero means the access spills into the next word.
        if (mem.mem_rsp_valid)
          state_nx = (m8[7:4] != 4'b0) ? REQ1 : DONE;
      end
      REQ1: begin
        mem.mem_req_valid = 1'b1;
        mem.mem_we        = r_we;
        mem.mem_addr      = {word1, 2'b00};
        mem.mem_mask      = m8[7:4];
        mem.mem_wdata     = w64[63:32];
        if (mem.mem_req_ready)
          state_nx = WAIT1;
      end
      WAIT1: begin
        if (mem.mem_rsp_valid)
          state_nx = DONE;
      end
      DONE: begin
        req.resp_valid = 1'b1;
        req.resp_err   = r_err;
        req.resp_rdata = (r_we || r_err) ? 32'b0 : ld;
        state_nx       = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
